ternary_semiosis_array: RTL
===========================

# ternary_semiosis_array

Multi-channel, handshaked successor to the single semiosis chain register. The block accepts one vector of CHANNELS (object, sign) trit pairs and runs an independent feedback semiosis chain on every channel in parallel. Each chain has a true interpretant register, a parametrised convergence threshold and a step timeout. When every channel has finished, the block returns per-channel final mediation, status masks and step counts over a valid/ready output port. It sits between the sign-classification front end and the downstream interpretant consumers.

## Interface
- CHANNELS, 4: number of parallel chains; must be ≥ 1.
- STABLE_N, 3: consecutive stable steps required to declare convergence; must be ≥ 1.
- MAX_CYC, 15: step limit per channel before timeout; must be ≥ 1. CW = $clog2(MAX_CYC+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  high only in state IDLE.
- in_object  in  2*CHANNELS  per-channel object trit; channel c occupies [2c+1:2c].
- in_sign  in  2*CHANNELS  per-channel initial sign trit.
- out_valid  out  1  result valid; high only in state DONE.
- out_ready  in  1  consumer accepts result.
- out_mediation  out  2*CHANNELS  final mediation per channel.
- out_converged  out  CHANNELS  channel reached STABLE_N.
- out_timeout  out  CHANNELS  channel hit MAX_CYC without converging.
- out_fault  out  CHANNELS  channel loaded with a fault code.
- out_cycles  out  CW*CHANNELS  steps taken per channel.
- Trit encoding: 00 = −1, 01 = 0, 10 = +1, 11 = fault.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on in_valid & in_ready. Per channel, load:
  - obj_r ← object
  - sign_r ← sign
  - interp_r ← 01
  - stable ← 0
  - steps ← 0
  - fin ← 0
- Fault at load: if object or sign is 11, set fin=1, fault=1, mediation=11 and steps=0. The channel never steps.
- Mediation function m = maj(obj_r, sign_r, interp_r):
  - If any two operands are equal, m is that value.
  - If all three differ, m = 01.
- Per RUN cycle, for every channel with fin=0, one step:
  - sign_r ← interp_r
  - interp_r ← m
  - steps ← steps+1
  - stable ← (m == interp_r) ? stable+1 : 0
- Convergence: if the new stable value equals STABLE_N, set fin=1 and converged=1.
- Timeout: otherwise, if the new steps value equals MAX_CYC, set fin=1 and timeout=1. If both conditions occur on the same step, converged wins and timeout stays 0.
- Finished channels freeze all registers.
- RUN → DONE at the edge where every channel's next fin is 1. If all channels faulted at load, RUN lasts exactly one cycle with no steps.
- DONE → IDLE on out_ready. The result registers hold until the next load.
- in_valid is ignored outside IDLE. Exactly one of converged, timeout or fault is set per channel in DONE.

## Timing
- Reset, asynchronous, effective immediately, including mid-RUN or mid-DONE. In-flight results are discarded, and no partial result is ever presented. Values during reset:
  - state = IDLE, so in_ready = 1
  - out_valid = 0
  - out_mediation = all 01
  - all masks = 0
  - out_cycles = 0
- Accept edge ends cycle T. RUN occupies T+1..T+k, where k = max steps over non-fault channels (k = 1 if all faulted). out_valid is high from T+k+1.
- Output data is stable and unchanged while out_valid=1 and out_ready=0.
- Handshake completes on an edge with out_valid & out_ready. in_ready rises in the next cycle; there is no same-cycle load bypass.
- out_mediation = interp_r for non-fault channels and 11 for fault channels. out_cycles = steps.
- Throughput: at most one vector per k+2 cycles.

## Test plan
- Convergence, CHANNELS=1, defaults: object 10, sign 10 → mediation sequence +1,+1,+1,+1. Required: out_valid at T+5, out_mediation 10, converged 1, out_cycles 4.
- All-distinct start: object 00, sign 10 → steps 1..3 give m 0,0,0. Required: converged at out_cycles 3, out_mediation 01.
- Timeout, MAX_CYC=2: object 10, sign 10 → stable count 1 at step 2. Required: timeout 1, converged 0, out_cycles 2, out_mediation 10, out_valid at T+3.
- Mixed vector, CHANNELS=4: channel0 (10,10), channel1 (00,10), channel2 (11,01), channel3 (01,01). Required:
  - masks: converged 1011, fault 0100
  - cycles: 4/3/0/3
  - out_valid at T+5
  - channel2 mediation 11
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: all outputs constant, in_ready 0, in_valid pulses ignored. Raise out_ready: IDLE next cycle, next vector accepted.
- Reset mid-RUN: assert rst_n=0 at step 2 of the first scenario. Required: out_valid 0, in_ready 1, outputs at reset values immediately. A fresh vector after release completes normally.

Source files
------------

// File: rtl/ternary_semiosis_array.sv
// ternary_semiosis_array: CHANNELS independent ternary semiosis chains.
// A vector is loaded through a valid/ready input port, each chain steps
// until it converges, times out or was faulted at load, and the per-channel
// results are returned through a valid/ready output port.
module ternary_semiosis_array #(
  parameter int CHANNELS = 4,
  parameter int STABLE_N = 3,
  parameter int MAX_CYC  = 15,
  localparam int CW      = $clog2(MAX_CYC + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*CHANNELS-1:0]    in_object,
  input  logic [2*CHANNELS-1:0]    in_sign,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*CHANNELS-1:0]    out_mediation,
  output logic [CHANNELS-1:0]      out_converged,
  output logic [CHANNELS-1:0]      out_timeout,
  output logic [CHANNELS-1:0]      out_fault,
  output logic [CW*CHANNELS-1:0]   out_cycles
);

  localparam int SW = $clog2(STABLE_N + 1);

  localparam logic [1:0] TRIT_ZERO  = 2'b01;
  localparam logic [1:0] TRIT_FAULT = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;

  logic [CHANNELS-1:0][1:0]    obj_r, sign_r, interp_r;
  logic [CHANNELS-1:0][SW-1:0] stable_r;
  logic [CHANNELS-1:0][CW-1:0] steps_r;
  logic [CHANNELS-1:0]         fin_r, conv_r, tout_r, fault_r;

  logic [CHANNELS-1:0][1:0]    med_nx;
  logic [CHANNELS-1:0][SW-1:0] stable_nx;
  logic [CHANNELS-1:0][CW-1:0] steps_nx;
  logic [CHANNELS-1:0]         conv_hit, tout_hit, fin_nx;
  logic                        all_fin;

  // Majority of three trits; all-distinct resolves to zero.
  function automatic logic [1:0] maj3(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c);
    if (a == b || a == c) return a;
    if (b == c)           return b;
    return TRIT_ZERO;
  endfunction

  // Candidate step results for every channel and the all-finished predicate.
  always_comb begin
    med_nx    = '0;
    stable_nx = '0;
    steps_nx  = '0;
    conv_hit  = '0;
    tout_hit  = '0;
    fin_nx    = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      med_nx[c]    = maj3(obj_r[c], sign_r[c], interp_r[c]);
      steps_nx[c]  = steps_r[c] + CW'(1);
      stable_nx[c] = (med_nx[c] == interp_r[c]) ? stable_r[c] + SW'(1) : '0;
      conv_hit[c]  = (stable_nx[c] == SW'(STABLE_N));
      tout_hit[c]  = !conv_hit[c] && (steps_nx[c] == CW'(MAX_CYC));
      fin_nx[c]    = fin_r[c] | conv_hit[c] | tout_hit[c];
    end
    all_fin = &fin_nx;
  end

  // Control FSM plus per-channel chain registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      obj_r    <= '0;
      sign_r   <= '0;
      interp_r <= {CHANNELS{TRIT_ZERO}};
      stable_r <= '0;
      steps_r  <= '0;
      fin_r    <= '0;
      conv_r   <= '0;
      tout_r   <= '0;
      fault_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
              obj_r[c]    <= in_object[2*c +: 2];
              sign_r[c]   <= in_sign[2*c +: 2];
              interp_r[c] <= TRIT_ZERO;
              stable_r[c] <= '0;
              steps_r[c]  <= '0;
              conv_r[c]   <= 1'b0;
              tout_r[c]   <= 1'b0;
              fault_r[c]  <= (in_object[2*c +: 2] == TRIT_FAULT) ||
                             (in_sign[2*c +: 2] == TRIT_FAULT);
              fin_r[c]    <= (in_object[2*c +: 2] == TRIT_FAULT) ||
                             (in_sign[2*c +: 2] == TRIT_FAULT);
            end
            state <= RUN;
          end
        end
        RUN: begin
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!fin_r[c]) begin
              sign_r[c]   <= interp_r[c];
              interp_r[c] <= med_nx[c];
              steps_r[c]  <= steps_nx[c];
              stable_r[c] <= stable_nx[c];
              fin_r[c]    <= fin_nx[c];
              conv_r[c]   <= conv_hit[c];
              tout_r[c]   <= tout_hit[c];
            end
          end
          if (all_fin) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode: fault channels report the fault code instead of the interpretant.
  always_comb begin
    out_mediation = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      out_mediation[2*c +: 2] = fault_r[c] ? TRIT_FAULT : interp_r[c];
    end
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign out_converged = conv_r;
  assign out_timeout   = tout_r;
  assign out_fault     = fault_r;
  assign out_cycles    = steps_r;

endmodule
